// File: rtl/delay_line_pkg.sv
// Shared constants and helpers for the per-channel steering delay line.
package delay_line_pkg;

  localparam int DEFAULT_DEPTH = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/delay_line_if.sv
// Sample stream and control bundle between the ADC front end and one delay line.
interface delay_line_if
  import delay_line_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int DW    = clog2(DEPTH + 1)
);

  logic          ce;
  logic          clr;
  logic [DW-1:0] delay;
  logic [W-1:0]  D;
  logic [W-1:0]  Q;
  logic          vld;
  logic          dly_err;

  modport master (
    output ce, clr, delay, D,
    input  Q, vld, dly_err
  );

  modport slave (
    input  ce, clr, delay, D,
    output Q, vld, dly_err
  );

endinterface

// File: rtl/delay_line_ring_buf.sv
// Circular sample store: one write at the pointer, one combinational read.
module delay_line_ring_buf
  import delay_line_pkg::*;
#(
  parameter  int W     = 16,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] ridx_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW-1:0] wp_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] wp_d;

  // explicit wrap so non power-of-two depths work
  always_comb begin
    wp_d = (wp_q == LAST) ? '0 : wp_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q <= '0;
    end else if (clr_i) begin
      wp_q <= '0;
    end else if (we_i) begin
      wp_q <= wp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) mem_q[wp_q] <= wdata_i;
  end

  assign rdata_o = mem_q[ridx_i];
  assign wp_o    = wp_q;

endmodule

// File: rtl/delay_line.sv
// Per-channel steering delay: Q is D delayed by 0..DEPTH sample strobes.
module delay_line
  import delay_line_pkg::*;
#(
  parameter  int W     = 16,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int DW    = clog2(DEPTH + 1),
  localparam int AW    = clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  delay_line_if.slave bus
);

  localparam logic [DW-1:0] DMAX = DW'(DEPTH);
  localparam logic [DW:0]   DADD = (DW + 1)'(DEPTH);

  logic [DW-1:0] d_eff;
  logic          over;
  logic [DW:0]   diff;
  logic [DW:0]   idx;
  logic [AW-1:0] ridx;
  logic [AW-1:0] wp;
  logic [W-1:0]  rdata;
  logic          we;

  logic [DW-1:0] fill_q, fill_d;
  logic [W-1:0]  q_q, q_d;
  logic          vld_q, vld_d;
  logic          err_q;

  assign we = bus.ce & ~bus.clr;

  delay_line_ring_buf #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (bus.clr),
    .we_i    (we),
    .wdata_i (bus.D),
    .ridx_i  (ridx),
    .rdata_o (rdata),
    .wp_o    (wp)
  );

  always_comb begin
    over  = bus.delay > DMAX;
    d_eff = over ? DMAX : bus.delay;
    // pre-write pointer minus delay, folded back into 0..DEPTH-1
    diff  = {1'b0, DW'(wp)} - {1'b0, d_eff};
    idx   = diff[DW] ? diff + DADD : diff;
    ridx  = AW'(idx);
  end

  always_comb begin
    fill_d = (fill_q == DMAX) ? fill_q : fill_q + 1'b1;
    q_d    = '0;
    vld_d  = 1'b0;
    unique case (1'b1)
      (d_eff == '0): begin
        q_d   = bus.D;
        vld_d = 1'b1;
      end
      (d_eff != '0 && fill_q >= d_eff): begin
        q_d   = rdata;
        vld_d = 1'b1;
      end
      default: begin
        q_d   = '0;
        vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_q <= '0;
      q_q    <= '0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.clr) begin
      fill_q <= '0;
      q_q    <= '0;
      vld_q  <= 1'b0;
    end else if (bus.ce) begin
      fill_q <= fill_d;
      q_q    <= q_d;
      vld_q  <= vld_d;
      err_q  <= err_q | over;
    end
  end

  assign bus.Q       = q_q;
  assign bus.vld     = vld_q;
  assign bus.dly_err = err_q;

endmodule

// File: tb/tb_delay_line.sv
// Randomised bench: two delay lines (DEPTH 32 and 20) against a history-queue model.
module tb_delay_line;

  logic clk;
  logic rst;

  delay_line_if #(.W(16), .DEPTH(32)) ia ();
  delay_line_if #(.W(16), .DEPTH(20)) ib ();

  delay_line #(.W(16), .DEPTH(32)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ia)
  );

  delay_line #(.W(16), .DEPTH(20)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] ha[$];
  logic [15:0] hb[$];
  logic [15:0] eqa, eqb;
  logic        eva, evb, eea, eeb;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // expected output from "sample presented d strobes ago", newest at h[0]
  task automatic calc(input int dep, input int dly, input logic [15:0] d,
                      input logic [15:0] h[$],
                      output logic [15:0] q, output logic v);
    int de;
    de = (dly > dep) ? dep : dly;
    if (de == 0) begin
      q = d;
      v = 1'b1;
    end else if (h.size() >= de) begin
      q = h[de-1];
      v = 1'b1;
    end else begin
      q = '0;
      v = 1'b0;
    end
  endtask

  task automatic model_reset();
    ha.delete();
    hb.delete();
    eqa = '0; eqb = '0;
    eva = 1'b0; evb = 1'b0;
    eea = 1'b0; eeb = 1'b0;
  endtask

  task automatic model_edge();
    int dla, dlb;
    dla = int'(ia.delay);
    dlb = int'(ib.delay);
    if (!rst) begin
      model_reset();
    end else if (ia.clr) begin
      ha.delete();
      hb.delete();
      eqa = '0; eqb = '0;
      eva = 1'b0; evb = 1'b0;
    end else if (ia.ce) begin
      eea = eea | (dla > 32);
      eeb = eeb | (dlb > 20);
      calc(32, dla, ia.D, ha, eqa, eva);
      calc(20, dlb, ib.D, hb, eqb, evb);
      ha.push_front(ia.D);
      hb.push_front(ib.D);
      if (ha.size() > 32) void'(ha.pop_back());
      if (hb.size() > 20) void'(hb.pop_back());
    end
  endtask

  task automatic compare();
    chk("a_q",   32'(ia.Q),       32'(eqa));
    chk("a_vld", 32'(ia.vld),     32'(eva));
    chk("a_err", 32'(ia.dly_err), 32'(eea));
    chk("b_q",   32'(ib.Q),       32'(eqb));
    chk("b_vld", 32'(ib.vld),     32'(evb));
    chk("b_err", 32'(ib.dly_err), 32'(eeb));
  endtask

  task automatic step(input logic r, input logic ce, input logic clr,
                      input int da, input int db, input logic [15:0] d);
    @(negedge clk);
    rst      = r;
    ia.ce    = ce;     ib.ce    = ce;
    ia.clr   = clr;    ib.clr   = clr;
    ia.delay = 6'(da); ib.delay = 5'(db);
    ia.D     = d;      ib.D     = d;
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  initial begin
    int da, db;
    rst = 1'b0;
    ia.ce = 1'b0; ib.ce = 1'b0;
    ia.clr = 1'b0; ib.clr = 1'b0;
    ia.delay = '0; ib.delay = '0;
    ia.D = '0; ib.D = '0;
    model_reset();

    for (int i = 0; i < 6; i++)
      step(1'b0, 1'(i % 2), 1'b0, 3, 3, 16'($urandom));

    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b0, 1'b0, 0, 0, 16'($urandom));

    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 0, 0, 16'(i));
      chk("d0_q", 32'(ia.Q), 32'(i));
    end

    step(1'b1, 1'b0, 1'b1, 5, 5, 16'h0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 5, 5, 16'(i));
      if (i > 5) chk("d5_q", 32'(ia.Q), 32'(i - 5));
    end

    step(1'b1, 1'b0, 1'b1, 32, 20, 16'h0);
    for (int i = 1; i <= 100; i++) begin
      step(1'b1, 1'b1, 1'b0, 32, 20, 16'(i));
      if (i == 100) chk("full32_s100", 32'(ia.Q), 32'd68);
      if (i == 50)  chk("full20_s50",  32'(ib.Q), 32'd30);
    end

    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 1'b0, 40, 20, 16'($urandom));
    chk("clamp_err", 32'(ia.dly_err), 32'd1);

    for (int s = 0; s < 10; s++) begin
      step(1'b1, 1'b1, 1'b0, 3, 3, 16'($urandom));
      step(1'b1, 1'b0, 1'b0, 3, 3, 16'($urandom));
      step(1'b1, 1'b0, 1'b0, 3, 3, 16'($urandom));
    end
    step(1'b1, 1'b0, 1'b1, 3, 3, 16'h0);
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 1'b1, 1'b0, 3, 3, 16'($urandom));
      step(1'b1, 1'b0, 1'b0, 3, 3, 16'($urandom));
      step(1'b1, 1'b0, 1'b0, 3, 3, 16'($urandom));
    end

    da = 7; db = 7;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        da = $urandom_range(0, 40);
        db = $urandom_range(0, 31);
      end
      step(1'b1, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0), da, db, 16'($urandom));
    end

    #2;
    rst = 1'b0;
    #1;
    chk("arst_a_q",   32'(ia.Q),       32'd0);
    chk("arst_a_vld", 32'(ia.vld),     32'd0);
    chk("arst_a_err", 32'(ia.dly_err), 32'd0);
    chk("arst_b_q",   32'(ib.Q),       32'd0);
    model_reset();
    step(1'b0, 1'b1, 1'b0, da, db, 16'($urandom));

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        da = $urandom_range(0, 40);
        db = $urandom_range(0, 31);
      end
      step(1'b1, 1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) == 0), da, db, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
